sram_req_arbiter: RTL and testbench

- Shares one SRAM-like (en/addr_ok/data_ok) data port of the AXI transfer bridge among NUM_REQ requesters: D-cache refill, write buffer and uncached unit.
- Grants requests round-robin and records the requester ID of each accepted transaction in an in-order tracking FIFO.
- Routes each data_ok/rdata back to its owner.
- Forbids read/write interleaving while transactions are outstanding, so bridge responses always return in issue order.

---
 rtl/sram_req_arbiter_pkg.sv | 29 ++
 rtl/sram_req_arbiter_req_order_fifo.sv | 49 ++++
 rtl/sram_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM data-port arbiter: field widths, FSM encoding,
// parameter defaults and the requester-ID width helper.
package sram_req_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;

  localparam int NUM_REQ_DEF = 3;
  localparam int DEPTH_DEF   = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_req_arbiter_req_order_fifo.sv
// In-order FIFO of requester IDs for accepted transactions; the head names the
// owner of the next bridge response.
module req_order_fifo #(
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [IDW-1:0]           din_i,
  output logic [IDW-1:0]           head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [IDW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;
  logic           push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Payload needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one SRAM-like bridge data port among NUM_REQ
// requesters, with in-order response routing and read/write direction fencing.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [SIZE_W*NUM_REQ-1:0] req_size,
  input  logic [STRB_W*NUM_REQ-1:0] req_wstrb,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_addr_ok,
  output logic [NUM_REQ-1:0]        req_data_ok,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      out_en,
  output logic                      out_wr,
  output logic [SIZE_W-1:0]         out_size,
  output logic [STRB_W-1:0]         out_wstrb,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_wdata,
  input  logic                      out_addr_ok,
  input  logic                      out_data_ok,
  input  logic [DATA_W-1:0]         out_rdata,
  output logic                      busy,
  output logic                      err_orphan
);
  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [0:0]         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic               dir_q, dir_d;
  logic               orph_q, orph_d;

  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     grant;
  logic               accept, pop;
  sram_req_t          sel;

  logic [IDW-1:0]     fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;

  // Direction is only fenced while something is outstanding.
  always_comb begin
    int idx;
    idx       = 0;
    elig      = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_en[i] & ~fifo_full & (fifo_empty | (req_wr[i] == dir_q));
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign grant  = (state_q == S_LOCK) ? grant_q : win_id;
  assign out_en = resetn & ((state_q == S_LOCK) ? req_en[grant_q] : win_found);
  assign accept = out_en & out_addr_ok;
  assign pop    = out_data_ok & ~fifo_empty;

  always_comb begin
    int g;
    g   = int'(grant);
    sel = '0;
    if (out_en) begin
      sel.wr    = req_wr[grant];
      sel.size  = req_size[g*SIZE_W +: SIZE_W];
      sel.wstrb = req_wstrb[g*STRB_W +: STRB_W];
      sel.addr  = req_addr[g*ADDR_W +: ADDR_W];
      sel.wdata = req_wdata[g*DATA_W +: DATA_W];
    end
  end

  assign out_wr    = sel.wr;
  assign out_size  = sel.size;
  assign out_wstrb = sel.wstrb;
  assign out_addr  = sel.addr;
  assign out_wdata = sel.wdata;

  always_comb begin
    req_addr_ok = '0;
    req_data_ok = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_ok[i] = accept & (grant == IDW'(i));
      req_data_ok[i] = pop & (fifo_head == IDW'(i));
    end
  end

  assign req_rdata  = pop ? out_rdata : '0;
  assign busy       = (fifo_count != '0) | out_en;
  assign err_orphan = orph_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    dir_d   = dir_q;
    orph_d  = orph_q | (out_data_ok & fifo_empty);
    case (state_q)
      S_IDLE: if (win_found && !out_addr_ok) begin
        state_d = S_LOCK;
        grant_d = win_id;
      end
      // A requester dropping req_en while locked releases the port.
      S_LOCK: if (!req_en[grant_q] || out_addr_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      dir_d = req_wr[grant];
      rr_d  = (int'(grant) + 1 == NUM_REQ) ? '0 : IDW'(int'(grant) + 1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      dir_q   <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
      orph_q  <= orph_d;
    end
  end

  req_order_fifo #(.DEPTH(DEPTH), .IDW(IDW)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (grant),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_sram_req_arbiter;
  localparam int NR    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NR-1:0]    req_en, req_wr;
  logic [2*NR-1:0]  req_size;
  logic [4*NR-1:0]  req_wstrb;
  logic [32*NR-1:0] req_addr, req_wdata;
  logic [NR-1:0]    req_addr_ok, req_data_ok;
  logic [31:0]      req_rdata;
  logic             out_en, out_wr;
  logic [1:0]       out_size;
  logic [3:0]       out_wstrb;
  logic [31:0]      out_addr, out_wdata;
  logic             out_addr_ok, out_data_ok;
  logic [31:0]      out_rdata;
  logic             busy, err_orphan;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int   q[$];
  int   m_lock = -1;
  int   m_rr   = 0;
  logic m_dir  = 1'b0;
  logic m_orph = 1'b0;
  logic [NR-1:0] acc_last = '0;
  logic [NR-1:0] hold = '0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .req_en(req_en), .req_wr(req_wr), .req_size(req_size), .req_wstrb(req_wstrb),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_addr_ok(req_addr_ok), .req_data_ok(req_data_ok), .req_rdata(req_rdata),
    .out_en(out_en), .out_wr(out_wr), .out_size(out_size), .out_wstrb(out_wstrb),
    .out_addr(out_addr), .out_wdata(out_wdata),
    .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_rdata(out_rdata),
    .busy(busy), .err_orphan(err_orphan)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: evaluated mid-cycle once inputs are stable; advances state for the next edge.
  initial forever begin
    logic [NR-1:0] e_aok, e_dok;
    logic e_en, e_wr, e_busy, e_orph;
    logic [1:0] e_size;
    logic [3:0] e_strb;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int g, cnt, j;
    bit acc, pop;
    @(negedge clk);
    e_aok = '0; e_dok = '0; e_en = 0; e_wr = 0; e_busy = 0; e_orph = 0;
    e_size = '0; e_strb = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    g = 0; acc = 0; pop = 0;
    if (!resetn) begin
      q.delete(); m_lock = -1; m_rr = 0; m_dir = 0; m_orph = 0;
    end else begin
      cnt = q.size();
      if (m_lock >= 0) begin
        g = m_lock;
        e_en = req_en[g];
      end else begin
        for (int k = 0; k < NR; k++) begin
          j = (m_rr + k) % NR;
          if (!e_en && req_en[j] && cnt < DEPTH && (cnt == 0 || req_wr[j] == m_dir)) begin
            e_en = 1; g = j;
          end
        end
      end
      if (e_en) begin
        e_wr = req_wr[g]; e_size = req_size[g*2 +: 2]; e_strb = req_wstrb[g*4 +: 4];
        e_addr = req_addr[g*32 +: 32]; e_wdata = req_wdata[g*32 +: 32];
      end
      acc = e_en && out_addr_ok;
      pop = out_data_ok && cnt > 0;
      if (acc) e_aok[g] = 1'b1;
      if (pop) begin e_dok[q[0]] = 1'b1; e_rdata = out_rdata; end
      e_busy = (cnt > 0) || e_en;
      e_orph = m_orph;
      if (out_data_ok && cnt == 0) m_orph = 1;
      if (pop) void'(q.pop_front());
      if (acc) begin q.push_back(g); m_dir = req_wr[g]; m_rr = (g + 1) % NR; end
      if (m_lock < 0 && e_en && !acc) m_lock = g;
      else if (m_lock >= 0 && (!e_en || acc)) m_lock = -1;
    end
    chk("m_out_en", out_en, e_en);
    chk("m_out_wr", out_wr, e_wr);
    chk("m_out_size", out_size, e_size);
    chk("m_out_wstrb", out_wstrb, e_strb);
    chk("m_out_addr", out_addr, e_addr);
    chk("m_out_wdata", out_wdata, e_wdata);
    chk("m_addr_ok", req_addr_ok, e_aok);
    chk("m_data_ok", req_data_ok, e_dok);
    chk("m_rdata", req_rdata, e_rdata);
    chk("m_busy", busy, e_busy);
    chk("m_orphan", err_orphan, e_orph);
    acc_last = e_aok;
  end

  // Requesters drop req_en after their addr_ok unless held for back-to-back traffic.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) if (acc_last[i] && !hold[i]) req_en[i] = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    resetn = 0; req_en = '0; out_addr_ok = 0; out_data_ok = 0; hold = '0;
    tick();
    resetn = 1;
  endtask

  initial begin
    req_en = '0; req_wr = '0; req_size = 6'b10_01_10; req_wstrb = 12'h3cf;
    req_addr = '0; out_addr_ok = 0; out_data_ok = 0; out_rdata = '0;
    for (int i = 0; i < NR; i++) req_wdata[i*32 +: 32] = 32'h5500_0000 + 32'(i);

    // reset, with a request already pending
    tick();
    req_en = 3'b001; out_addr_ok = 1;
    settle();
    chk("rst_out_en", out_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_ok", req_addr_ok, 0);
    chk("rst_orphan", err_orphan, 0);
    tick();
    req_en = '0; out_addr_ok = 0; resetn = 1;
    tick();

    // single read, response 3 cycles after accept
    req_addr[31:0] = 32'h1c00_0000; req_en = 3'b001; out_addr_ok = 1;
    settle();
    chk("s1_out_en", out_en, 1);
    chk("s1_out_addr", out_addr, 32'h1c00_0000);
    chk("s1_addr_ok", req_addr_ok, 3'b001);
    tick(); tick(); tick();
    out_data_ok = 1; out_rdata = 32'hdeadbeef;
    settle();
    chk("s1_data_ok", req_data_ok, 3'b001);
    chk("s1_rdata", req_rdata, 32'hdeadbeef);
    tick();
    out_data_ok = 0;

    // round-robin with continuous reads; one response per cycle trailing by one
    do_reset();
    for (int i = 0; i < NR; i++) req_addr[i*32 +: 32] = 32'h1000_0000 + 32'(i*16);
    hold = 3'b111; req_en = 3'b111; out_addr_ok = 1;
    for (int k = 0; k < 7; k++) begin
      out_data_ok = (k > 0); out_rdata = 32'ha0 + 32'(k);
      if (k == 6) req_en = '0;
      settle();
      if (k < 6) chk("s2_grant", req_addr_ok, 32'(1) << (k % 3));
      if (k > 0) chk("s2_route", req_data_ok, 32'(1) << ((k - 1) % 3));
      tick();
    end
    out_data_ok = 0; hold = '0;

    // lock: addr_ok withheld 4 cycles, competing req1 must not steal the port
    do_reset();
    req_addr[31:0] = 32'ha000_0000; req_addr[63:32] = 32'hb000_0000;
    req_en = 3'b001; out_addr_ok = 0;
    settle();
    chk("s3_out_en", out_en, 1);
    chk("s3_addr0", out_addr, 32'ha000_0000);
    tick();
    req_en[1] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      settle();
      chk("s3_hold_addr", out_addr, 32'ha000_0000);
      chk("s3_no_grant", req_addr_ok, 0);
      tick();
    end
    out_addr_ok = 1;
    settle();
    chk("s3_grant0", req_addr_ok, 3'b001);
    tick();
    settle();
    chk("s3_grant1", req_addr_ok, 3'b010);
    chk("s3_addr1", out_addr, 32'hb000_0000);
    tick();
    out_addr_ok = 0; out_data_ok = 1;
    settle();
    chk("s3_resp0", req_data_ok, 3'b001);
    tick();
    settle();
    chk("s3_resp1", req_data_ok, 3'b010);
    tick();
    out_data_ok = 0;

    // full: 4 outstanding blocks the 5th until the cycle after a pop
    do_reset();
    hold = 3'b001; req_en = 3'b001; out_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("s4_accept", req_addr_ok, 3'b001);
      tick();
    end
    settle();
    chk("s4_full_en", out_en, 0);
    chk("s4_full_busy", busy, 1);
    tick();
    out_data_ok = 1;
    settle();
    chk("s4_pop", req_data_ok, 3'b001);
    chk("s4_full_en_pop", out_en, 0);
    tick();
    out_data_ok = 0;
    settle();
    chk("s4_accept5", req_addr_ok, 3'b001);
    tick();
    hold = '0; req_en = '0; out_data_ok = 1;
    for (int k = 0; k < 4; k++) tick();
    out_data_ok = 0;

    // direction fence: write waits for all reads to drain; req2 read goes first
    do_reset();
    req_wr = 3'b010;
    req_addr[63:32] = 32'hc000_0040; req_addr[95:64] = 32'hd000_0080;
    hold = 3'b001; req_en = 3'b001; out_addr_ok = 1;
    settle(); chk("s5_rd0", req_addr_ok, 3'b001); tick();
    settle(); chk("s5_rd1", req_addr_ok, 3'b001); tick();
    hold = '0; req_en = 3'b110;
    settle();
    chk("s5_read_first", req_addr_ok, 3'b100);
    chk("s5_no_write", out_wr, 0);
    tick();
    out_data_ok = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s5_wr_wait", out_en, 0);
      tick();
    end
    out_data_ok = 0;
    settle();
    chk("s5_wr_accept", req_addr_ok, 3'b010);
    chk("s5_wr_dir", out_wr, 1);
    tick();
    out_data_ok = 1;
    settle();
    chk("s5_wr_resp", req_data_ok, 3'b010);
    tick();
    out_data_ok = 0; req_wr = '0;

    // async reset while locked with 2 outstanding, then a stray response
    do_reset();
    hold = 3'b001; req_en = 3'b001; out_addr_ok = 1;
    tick(); tick();
    hold = '0; req_en = 3'b010; out_addr_ok = 0;
    tick();
    settle();
    chk("s6_lock_en", out_en, 1);
    chk("s6_busy_pre", busy, 1);
    resetn = 0;
    #1;
    chk("s6_rst_en", out_en, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_addr_ok", req_addr_ok, 0);
    tick();
    req_en = '0; resetn = 1;
    out_data_ok = 1;
    settle();
    chk("s6_stray_dok", req_data_ok, 0);
    tick();
    out_data_ok = 0;
    settle();
    chk("s6_orphan", err_orphan, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
